// File: rtl/timer_counter_pkg.sv
// Shared register-map, control-field and state definitions for the timer block.
// The CPU-side software headers are generated from these same values.
package timer_counter_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped 32-bit down-counting timer with one-shot and auto-reload modes
// and a maskable level interrupt.
module timer_counter
  import timer_counter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        IRQ
);

  state_t      state;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        flag;

  logic [1:0]  sel;
  logic        en;
  logic [1:0]  mode;
  logic        unused_addr;

  assign sel         = Addr[3:2];
  assign en          = ctrl[CTRL_EN];
  assign mode        = ctrl[CTRL_MODE_HI:CTRL_MODE_LO];
  assign unused_addr = ^{Addr[31:4], Addr[1:0]};

  // FSM transitions use the registered EN; a CPU write in the same cycle is
  // applied afterwards so it overrides anything the FSM did to CTRL or flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      ctrl   <= '0;
      preset <= '0;
      count  <= '0;
      flag   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en) state <= ST_LOAD;
        end
        ST_LOAD: begin
          count <= preset;
          state <= en ? ST_CNT : ST_IDLE;
        end
        ST_CNT: begin
          if (!en) begin
            state <= ST_IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            count <= '0;
            flag  <= 1'b1;
            state <= ST_INT;
          end
        end
        ST_INT: begin
          state <= ST_IDLE;
          if (mode == MODE_RELOAD) flag <= 1'b0;
          else                     ctrl[CTRL_EN] <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase

      if (WE) begin
        case (sel)
          REG_CTRL: begin
            ctrl <= WD[3:0];
            flag <= 1'b0;
          end
          REG_PRESET: begin
            preset <= WD;
            flag   <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign RD = (sel == REG_CTRL)   ? {28'b0, ctrl} :
              (sel == REG_PRESET) ? preset :
              (sel == REG_COUNT)  ? count  : 32'd0;

  assign IRQ = ctrl[CTRL_IM] & flag;

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: directed scenarios plus randomized bus traffic,
// all checked against a behavioural model of the timer.
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        IRQ;

  int total = 0;
  int bad   = 0;

  timer_counter dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .WD   (WD),
    .RD   (RD),
    .IRQ  (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: phase 0 = waiting for enable, 1 = arming (reload next),
  // 2 = running down, 3 = just expired.
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic        m_flag;
  int          m_phase;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] d);
    logic running;
    if (r) begin
      m_ctrl = '0; m_preset = '0; m_count = '0; m_flag = 1'b0; m_phase = 0;
      return;
    end
    running = m_ctrl[0];
    if (m_phase == 0) begin
      if (running) m_phase = 1;
    end else if (m_phase == 1) begin
      m_count = m_preset;
      m_phase = running ? 2 : 0;
    end else if (m_phase == 2) begin
      if (!running) m_phase = 0;
      else if (m_count > 1) m_count = m_count - 1;
      else begin
        m_count = 0; m_flag = 1'b1; m_phase = 3;
      end
    end else begin
      m_phase = 0;
      if (m_ctrl[2:1] == 2'b01) m_flag = 1'b0;
      else m_ctrl[0] = 1'b0;
    end
    if (w && a[3:2] == 2'd0) begin
      m_ctrl = d[3:0]; m_flag = 1'b0;
    end else if (w && a[3:2] == 2'd1) begin
      m_preset = d; m_flag = 1'b0;
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    case (a[3:2])
      2'd0:    return {28'b0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  // One clock: present inputs, take the edge, then read back register ca.
  task automatic cycle(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] ca);
    reset = r; WE = w; Addr = a; WD = d;
    @(posedge clk);
    model_step(r, w, a, d);
    #1;
    reset = 1'b0; WE = 1'b0; Addr = ca;
    #1;
    check("rd", RD, model_rd(ca));
    check("irq", {31'b0, IRQ}, {31'b0, m_flag & m_ctrl[3]});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [31:0] ca);
    cycle(1'b0, 1'b1, a, d, ca);
  endtask

  task automatic idle(input logic [31:0] ca);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, ca);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    cycle(1'b1, 1'b1, 32'h4, 32'h55, 32'h0);
  endtask

  logic [31:0] held;
  logic [31:0] a_r;
  logic [31:0] d_r;
  bit          found;

  initial begin
    reset = 1'b0; WE = 1'b0; Addr = '0; WD = '0;
    m_ctrl = '0; m_preset = '0; m_count = '0; m_flag = 1'b0; m_phase = 0;

    // Reset state: all readable registers zero, IRQ low
    do_reset();
    idle(32'h0); check("rst_ctrl", RD, 32'h0);
    idle(32'h4); check("rst_preset", RD, 32'h0);
    idle(32'h8); check("rst_count", RD, 32'h0);
    check("rst_irq", {31'b0, IRQ}, 32'h0);

    // One-shot, PRESET=3, IM set
    wr(32'h4, 32'd3, 32'h8);
    wr(32'h0, 32'h9, 32'h8);                 // edge t
    idle(32'h8); check("os_t1", RD, 32'd0);
    idle(32'h8); check("os_t2", RD, 32'd3);
    idle(32'h8); check("os_t3", RD, 32'd2);
    idle(32'h8); check("os_t4", RD, 32'd1);
    check("os_irq_t4", {31'b0, IRQ}, 32'h0);
    idle(32'h8); check("os_t5", RD, 32'd0);
    check("os_irq_t5", {31'b0, IRQ}, 32'h1);
    idle(32'h0); check("os_ctrl", RD, 32'h8);
    for (int i = 0; i < 4; i++) begin
      idle(32'h8); check("os_irq_hold", {31'b0, IRQ}, 32'h1);
    end
    wr(32'h0, 32'h8, 32'h0);
    check("os_irq_clr", {31'b0, IRQ}, 32'h0);

    // Auto-reload, PRESET=2: one-cycle IRQ pulse every 5 cycles
    do_reset();
    wr(32'h4, 32'd2, 32'h0);
    wr(32'h0, 32'hB, 32'h0);                 // edge t
    for (int k = 1; k <= 15; k++) begin
      idle(32'h0);
      check("ar_irq", {31'b0, IRQ}, {31'b0, (k >= 4 && (k - 4) % 5 == 0)});
      check("ar_en", {31'b0, RD[0]}, 32'h1);
    end

    // Disable mid-count: COUNT freezes, no IRQ
    do_reset();
    wr(32'h4, 32'd20, 32'h8);
    wr(32'h0, 32'h9, 32'h8);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      idle(32'h8);
      if (RD == 32'd10) found = 1'b1;
    end
    check("dis_reach10", {31'b0, found}, 32'h1);
    wr(32'h0, 32'h0, 32'h8);
    idle(32'h8);
    held = RD;
    for (int i = 0; i < 4; i++) begin
      idle(32'h8);
      check("dis_hold", RD, held);
      check("dis_noirq", {31'b0, IRQ}, 32'h0);
    end

    // COUNT is read-only; PRESET write mid-count only affects the next reload
    do_reset();
    wr(32'h4, 32'd6, 32'h8);
    wr(32'h0, 32'h3, 32'h8);
    idle(32'h8); idle(32'h8); idle(32'h8);
    held = RD;
    wr(32'h8, 32'hFFFF, 32'h8);
    check("ro_count", RD, held - 32'd1);
    wr(32'h4, 32'd4, 32'h8);
    check("pre_mid", RD, held - 32'd2);
    for (int i = 0; i < 6; i++) idle(32'h8);
    check("pre_reload", RD, 32'd4);

    // Reset mid-count, and reset with IRQ pending
    wr(32'h0, 32'h9, 32'h8);
    idle(32'h8);
    cycle(1'b1, 1'b1, 32'h0, 32'hF, 32'h8);
    check("rst_mid_count", RD, 32'h0);
    idle(32'h0); check("rst_mid_ctrl", RD, 32'h0);
    wr(32'h4, 32'd1, 32'h0);
    wr(32'h0, 32'h9, 32'h0);
    for (int i = 0; i < 4; i++) idle(32'h0);
    check("pend_irq", {31'b0, IRQ}, 32'h1);
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 32'h4);
    check("rst_pend_irq", {31'b0, IRQ}, 32'h0);
    check("rst_pend_preset", RD, 32'h0);

    // Randomized bus traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      a_r = {$urandom_range(0, 32'hFFFFFFF), 4'h0} | 32'($urandom_range(0, 15));
      if (a_r[3:2] == 2'd1) d_r = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 7));
      else if (a_r[3:2] == 2'd0) d_r = {$urandom_range(0, 32'hFFFFFFF), 4'($urandom_range(0, 15) | ($urandom_range(0, 3) != 0 ? 1 : 0))};
      else d_r = $urandom;
      if (a_r[3:2] == 2'd1 && d_r > 32'd64) d_r = d_r & 32'h3F;
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 5) == 0, a_r, d_r,
            32'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
